// File: rtl/alu_serial_seq_if.sv
// Issue-side handshake and result bus for the bit-serial ALU sequencer.
// The sub line exists only when ALU_SERIAL_SUB_EN is defined.
interface alu_serial_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             cin;
`ifdef ALU_SERIAL_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
`ifdef ALU_SERIAL_SUB_EN
        output sub,
`endif
        output start, a, b, op, cin,
        input  busy, done, result, cout, ovf, zero
    );

    modport slave (
`ifdef ALU_SERIAL_SUB_EN
        input  sub,
`endif
        input  start, a, b, op, cin,
        output busy, done, result, cout, ovf, zero
    );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: drives one alu_1b slice LSB-first over WIDTH cycles.
// Define ALU_SERIAL_SUB_EN to enable the subtract input (a - b via inverted B, carry-in 1).
module alu_1b (
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic       inv_a_i,
    input  logic       inv_b_i,
    input  logic [1:0] op_i,
    output logic       out_o,
    output logic       cout_o
);
    logic a_e, b_e;

    assign a_e = a_i ^ inv_a_i;
    assign b_e = b_i ^ inv_b_i;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        out_o  = 1'b0;
        cout_o = 1'b0;
        unique case (op_i)
            2'b00: begin
                out_o  = a_e ^ b_e ^ cin_i;
                cout_o = (a_e & b_e) | (cin_i & (a_e ^ b_e));
            end
            2'b01:   out_o = ~(a_e & b_e);
            2'b10:   out_o = a_e | b_e;
            default: out_o = a_e ^ b_e;
        endcase
    end
endmodule

module alu_serial_seq #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    alu_serial_seq_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, res_sr_q, result_q;
    logic [1:0]       op_q;
    logic             sub_q, carry_q, cout_q, ovf_q, zero_q;

    logic             accept, last_bit, sub_in;
    logic             slice_out, slice_cout;
    logic [WIDTH-1:0] res_next;

    // A new operation may be taken from IDLE or in the DONE cycle (back-to-back).
    assign accept   = bus.start && (state_q != SHIFT);
    assign last_bit = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
    assign res_next = {slice_out, res_sr_q[WIDTH-1:1]};

`ifdef ALU_SERIAL_SUB_EN
    assign sub_in = bus.sub && (bus.op == 2'b00);
`else
    assign sub_in = 1'b0;
`endif

    alu_1b u_slice (
        .a_i     (a_sr_q[0]),
        .b_i     (b_sr_q[0]),
        .cin_i   (carry_q),
        .inv_a_i (1'b0),
        .inv_b_i (sub_q),
        .op_i    (op_q),
        .out_o   (slice_out),
        .cout_o  (slice_cout)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = bus.start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == SHIFT);
        bus.done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            result_q <= '0;
            op_q     <= 2'b00;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (accept) begin
            a_sr_q  <= bus.a;
            b_sr_q  <= bus.b;
            op_q    <= bus.op;
            sub_q   <= sub_in;
            carry_q <= sub_in ? 1'b1 : bus.cin;
            cnt_q   <= '0;
        end else if (state_q == SHIFT) begin
            a_sr_q   <= a_sr_q >> 1;
            b_sr_q   <= b_sr_q >> 1;
            res_sr_q <= res_next;
            carry_q  <= slice_cout;
            cnt_q    <= cnt_q + CW'(1);
            if (last_bit) begin
                // carry_q here is the carry into the MSB; ovf compares it with the carry out.
                result_q <= res_next;
                zero_q   <= (res_next == '0);
                cout_q   <= (op_q == 2'b00) && slice_cout;
                ovf_q    <= (op_q == 2'b00) && (carry_q ^ slice_cout);
            end
        end
    end

    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: directed corner cases plus random operations
// checked against an arithmetic reference model.
module tb_alu_serial_seq;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] result;
        logic         cout;
        logic         ovf;
        logic         zero;
        int           done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    logic [W-1:0] hold_res = '0;

    alu_serial_seq_if #(.WIDTH(W)) bus ();

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] op, input logic cin, input logic sub);
        exp_t         e;
        logic [W:0]   s;
        logic [W-1:0] bb;
        logic         c;
        e = '0;
        case (op)
            2'b00: begin
                bb = sub ? ~b : b;
                c  = sub ? 1'b1 : cin;
                s  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
                e.result = s[W-1:0];
                e.cout   = s[W];
                e.ovf    = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
            end
            2'b01:   e.result = ~(a & b);
            2'b10:   e.result = a | b;
            default: e.result = a ^ b;
        endcase
        e.zero = (e.result == '0);
        return e;
    endfunction

    // Called at a falling edge; waits out any running op, then presents one start pulse.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op, input logic cin, input logic sub);
        exp_t e;
        int   guard = 0;
        while (bus.busy && guard < 4 * W) begin
            @(negedge clk);
            guard++;
        end
        check("busy_before_issue", bus.busy, 0);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.op    = op;
        bus.cin   = cin;
`ifdef ALU_SERIAL_SUB_EN
        bus.sub   = sub;
`endif
        e          = model(a, b, op, cin, sub);
        e.done_cyc = cyc + 1 + W;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.op    = 2'($urandom);
        bus.cin   = 1'($urandom);
        check("busy_after_accept", bus.busy, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done with empty scoreboard (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    check("result", bus.result, e.result);
                    check("cout", bus.cout, e.cout);
                    check("ovf", bus.ovf, e.ovf);
                    check("zero", bus.zero, e.zero);
                    check("busy_in_done", bus.busy, 0);
                    hold_res = e.result;
                end
            end else begin
                check("result_hold", bus.result, hold_res);
            end
        end
    end

    initial begin
        logic sub_r;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.op    = 2'b00;
        bus.cin   = 1'b0;
`ifdef ALU_SERIAL_SUB_EN
        bus.sub   = 1'b0;
`endif
        #2 rst = 1'b0;
        #1;
        check("rst_result", bus.result, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_zero", bus.zero, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Carry/overflow corners and the logic ops.
        issue(16'h0001, 16'hFFFF, 2'b00, 1'b0, 1'b0);
        issue(16'h7FFF, 16'h0001, 2'b00, 1'b0, 1'b0);
        issue(16'h1234, 16'h0001, 2'b00, 1'b1, 1'b0);
        issue(16'hAAAA, 16'hFFFF, 2'b01, 1'b0, 1'b0);
        issue(16'h00F0, 16'h0F00, 2'b10, 1'b0, 1'b0);
        issue(16'hFFFF, 16'hFFFF, 2'b11, 1'b1, 1'b0);
        repeat (W + 2) @(negedge clk);

        // Abort an add mid-flight; outputs must clear without waiting for a clock.
        issue(16'h00FF, 16'h0001, 2'b00, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        sb.delete();
        hold_res = '0;
        #1;
        check("abort_result", bus.result, 0);
        check("abort_zero", bus.zero, 0);
        check("abort_cout", bus.cout, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(16'h00FF, 16'h0001, 2'b00, 1'b0, 1'b0);

        // A start pulse while busy must be dropped; then chain two ops with no gap.
        issue(16'h4000, 16'h4000, 2'b00, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'hDEAD;
        bus.b     = 16'hBEEF;
        @(negedge clk);
        bus.start = 1'b0;
        issue(16'hF0F0, 16'h0FF0, 2'b11, 1'b0, 1'b0);
        issue(16'h8000, 16'h8000, 2'b00, 1'b0, 1'b0);

`ifdef ALU_SERIAL_SUB_EN
        issue(16'h0005, 16'h0007, 2'b00, 1'b0, 1'b1);
        issue(16'h0007, 16'h0005, 2'b00, 1'b0, 1'b1);
        issue(16'h8000, 16'h0001, 2'b00, 1'b1, 1'b1);
        issue(16'h1234, 16'h0F0F, 2'b10, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 40; i++) begin
`ifdef ALU_SERIAL_SUB_EN
            sub_r = 1'($urandom);
`else
            sub_r = 1'b0;
`endif
            issue(W'($urandom), W'($urandom), 2'($urandom), 1'($urandom), sub_r);
            if ($urandom_range(0, 2) == 0) repeat (W + $urandom_range(1, 3)) @(negedge clk);
        end

        for (int i = 0; i < 4 * W && sb.size() != 0; i++) @(negedge clk);
        repeat (W + 4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
